vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Produces pixel counters, sync pulses, an active-video `draw` flag and frame/line strobes for any resolution and porch set.
- Sits between the pixel-clock domain and the pixel/framebuffer pipeline.
- All outputs are registered and mutually aligned, so downstream logic can use hcount, vcount and draw from the same cycle.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CNT_W, 10, counter width; must hold max(H_TOTAL, V_TOTAL)-1

Ports:
clk  in  1  pixel-domain clock
rst  in  1  asynchronous, active-high reset
en  in  1  pixel tick; counters advance only when high
hcount  out  CNT_W  current pixel column
vcount  out  CNT_W  current line
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
draw  out  1  high iff hcount < H_ACTIVE and vcount < V_ACTIVE
line_start  out  1  one-cycle pulse when hcount becomes 0
frame_start  out  1  one-cycle pulse when (hcount,vcount) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration error if CNT_W is too narrow or any sync width is 0.
- Reset values (asynchronous, immediate):
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1 (last back-porch pixel).
  - draw=0; hsync=~HS_POL; vsync=~VS_POL; line_start=0; frame_start=0.
- First en after reset moves counters to (0,0) with draw=1, line_start=1, frame_start=1.
- Horizontal counter, on en:
  - hcount==H_TOTAL-1 -> 0, otherwise hcount+1.
- Vertical counter, advances only on an en cycle where hcount wraps:
  - vcount==V_TOTAL-1 -> 0, otherwise vcount+1.
- Alignment:
  - Next-state counters are computed combinationally.
  - hsync/vsync/draw/strobes are decoded from the next-state values and registered in the same edge as the counters.
  - Zero skew between counters and flags; latency from en to updated outputs is 1 clk.
- hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
  - vsync changes together with hcount going to 0.
- en low:
  - Counters, draw, hsync and vsync hold.
  - line_start and frame_start go to 0 (strobes last exactly one cycle per event).
- Reset asserted mid-frame: all outputs take reset values within the same cycle. Restart is identical to power-up.
- Comparisons are unsigned at CNT_W. There is no X propagation; counters are always defined after reset.

Optional Feature:
VGA_TIMING_BORDER_EN
- Defined:
  - Adds output `border` (1 bit, reset 0), registered and aligned like draw.
  - border is high when draw is high and (hcount==0 or hcount==H_ACTIVE-1 or vcount==0 or vcount==V_ACTIVE-1).
  - Used for a test-pattern outline.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Package vga_timing_pkg:
  - localparams for the 640x480@60 default set.
  - Function timing_total(active, fp, sync, bp).
  - Function in_window(cnt, lo, hi) for the half-open range test.
- Sub-module vga_axis_counter (parameters TOTAL, CNT_W; ports clk, rst, inc, cnt, wrap), instantiated once for horizontal and once for vertical.
  - Horizontal instance: inc = en.
  - Vertical instance: inc = en & h_wrap.

Test Plan:
- Reset check: assert rst with en=1 -> hcount=799, vcount=524, draw=0, hsync=1, vsync=1, strobes 0. Release rst, first en -> (0,0), draw=1, line_start=1, frame_start=1.
- Default timing, en tied high -> hsync low exactly for hcount 656..751 (96 clks) on every line. vsync low for vcount 490..491. draw=0 at hcount 640 and at vcount 480.
- Line/frame wrap -> (799,10) goes to (0,11) with line_start=1 and frame_start=0. (799,524) goes to (0,0) with frame_start=1. Frame period is 420000 en cycles.
- en at 1-in-4 duty -> counters step once per en only. Strobes are single-cycle and never repeated while en is low. Frame period is 1680000 clks.
- Async reset asserted at (300,200) between clock edges -> outputs take reset values before the next edge. Post-release sequence matches the reset check.
- Small config (H 8/2/2/2, V 4/1/1/1, HS_POL=1), built with and without VGA_TIMING_BORDER_EN:
  - H_TOTAL=14; hsync high at hcount 10..11.
  - With the macro: border=1 on the outline pixels of the 8x4 active area only.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default timing set and shared raster helpers.
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;
  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic logic in_window(input int unsigned cnt, input int unsigned lo, input int unsigned hi);
    return cnt >= lo && cnt < hi;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: modulo-TOTAL raster axis counter parked at TOTAL-1 after reset.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);
  assign wrap = inc && cnt == CNT_W'(TOTAL - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= CNT_W'(TOTAL - 1);
    else if (inc) cnt <= wrap ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with flags decoded from next-state counters; optional border output via VGA_TIMING_BORDER_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             draw,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_BORDER_EN
  ,output logic            border
`endif
);
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);
  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_cfg
    $error("vga_timing_gen: CNT_W too narrow or zero sync width");
  end
  logic             h_wrap, v_wrap, draw_nxt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  vga_axis_counter #(.TOTAL(H_TOTAL), .CNT_W(CNT_W)) u_h (
    .clk, .rst, .inc(en), .cnt(hcount), .wrap(h_wrap)
  );
  vga_axis_counter #(.TOTAL(V_TOTAL), .CNT_W(CNT_W)) u_v (
    .clk, .rst, .inc(en & h_wrap), .cnt(vcount), .wrap(v_wrap)
  );
  // Mirror the counters' next state so every flag lands on the same edge as the counts.
  always_comb begin
    h_nxt    = h_wrap ? '0 : (en ? hcount + CNT_W'(1) : hcount);
    v_nxt    = v_wrap ? '0 : (h_wrap ? vcount + CNT_W'(1) : vcount);
    draw_nxt = in_window(32'(h_nxt), 0, H_ACTIVE) && in_window(32'(v_nxt), 0, V_ACTIVE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      draw        <= 1'b0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      draw        <= draw_nxt;
      hsync       <= in_window(32'(h_nxt), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? HS_ACT : ~HS_ACT;
      vsync       <= in_window(32'(v_nxt), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? VS_ACT : ~VS_ACT;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
`ifdef VGA_TIMING_BORDER_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) border <= 1'b0;
    else border <= draw_nxt && (h_nxt == '0 || h_nxt == CNT_W'(H_ACTIVE - 1) ||
                                v_nxt == '0 || v_nxt == CNT_W'(V_ACTIVE - 1));
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default 640x480 and a small 14x7 config.
module tb_vga_timing_gen;
  logic clk = 1'b0, rst, en_d, en_s;
  logic [9:0] d_h, d_v;
  logic [3:0] s_h, s_v;
  logic d_hs, d_vs, d_draw, d_ls, d_fs;
  logic s_hs, s_vs, s_draw, s_ls, s_fs;
  int total = 0, bad = 0;
`ifdef VGA_TIMING_BORDER_EN
  logic d_border, s_border;
`endif
  always #5 clk = ~clk;
  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .en(en_d), .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .draw(d_draw), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_BORDER_EN
    , .border(d_border)
`endif
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(0), .CNT_W(4)
  ) u_sml (
    .clk(clk), .rst(rst), .en(en_s), .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .draw(s_draw), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_BORDER_EN
    , .border(s_border)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n_hs, n_ls, n_fs;
    rst = 1'b1; en_d = 1'b1; en_s = 1'b1;
    step(2);
    chk("rst_d_h", d_h, 799); chk("rst_d_v", d_v, 524); chk("rst_d_draw", d_draw, 0);
    chk("rst_d_hs", d_hs, 1); chk("rst_d_vs", d_vs, 1); chk("rst_d_ls", d_ls, 0); chk("rst_d_fs", d_fs, 0);
    chk("rst_s_h", s_h, 13); chk("rst_s_v", s_v, 6); chk("rst_s_hs", s_hs, 0); chk("rst_s_vs", s_vs, 1);
    rst = 1'b0; en_d = 1'b0; en_s = 1'b0;
    step(1);
    chk("hold_d_h", d_h, 799); chk("hold_d_draw", d_draw, 0);
    en_d = 1'b1;
    step(1);
    chk("first_h", d_h, 0); chk("first_v", d_v, 0); chk("first_draw", d_draw, 1);
    chk("first_ls", d_ls, 1); chk("first_fs", d_fs, 1); chk("first_hs", d_hs, 1);
    step(1);
    chk("t1_h", d_h, 1); chk("t1_ls", d_ls, 0); chk("t1_fs", d_fs, 0);
    step(638); chk("h639_h", d_h, 639); chk("h639_draw", d_draw, 1);
    step(1);   chk("h640_draw", d_draw, 0);
    step(15);  chk("h655_hs", d_hs, 1);
    step(1);   chk("h656_hs", d_hs, 0);
    step(95);  chk("h751_h", d_h, 751); chk("h751_hs", d_hs, 0);
    step(1);   chk("h752_hs", d_hs, 1);
    step(47);  chk("h799_h", d_h, 799); chk("h799_v", d_v, 0); chk("h799_ls", d_ls, 0);
    step(1);
    chk("wrap_h", d_h, 0); chk("wrap_v", d_v, 1); chk("wrap_ls", d_ls, 1); chk("wrap_fs", d_fs, 0);
    chk("wrap_vs", d_vs, 1);
    n_hs = 0; n_ls = 0;
    repeat (800) begin
      @(negedge clk);
      if (!d_hs) n_hs++;
      if (d_ls) n_ls++;
    end
    chk("line_hs_low", n_hs, 96); chk("line_ls_cnt", n_ls, 1); chk("line2_v", d_v, 2); chk("line2_h", d_h, 0);
    step(300);
    chk("pre_arst_h", d_h, 300);
    #2 rst = 1'b1;
    #1;
    chk("arst_h", d_h, 799); chk("arst_v", d_v, 524); chk("arst_draw", d_draw, 0);
    chk("arst_hs", d_hs, 1); chk("arst_ls", d_ls, 0);
    @(negedge clk);
    rst = 1'b0; en_d = 1'b0;
    step(1); chk("post_arst_hold", d_h, 799);
    en_d = 1'b1;
    step(1);
    chk("restart_h", d_h, 0); chk("restart_v", d_v, 0); chk("restart_fs", d_fs, 1); chk("restart_ls", d_ls, 1);
    en_d = 1'b0;
    step(1);
    chk("enlow_h", d_h, 0); chk("enlow_fs", d_fs, 0); chk("enlow_ls", d_ls, 0); chk("enlow_draw", d_draw, 1);
    en_s = 1'b1;
    step(1);
    chk("s0_h", s_h, 0); chk("s0_v", s_v, 0); chk("s0_draw", s_draw, 1); chk("s0_ls", s_ls, 1);
    chk("s0_fs", s_fs, 1); chk("s0_hs", s_hs, 0); chk("s0_vs", s_vs, 1);
`ifdef VGA_TIMING_BORDER_EN
    chk("s0_border", s_border, 1);
`endif
    step(3);
`ifdef VGA_TIMING_BORDER_EN
    chk("s3_border", s_border, 1);
`endif
    step(4); chk("s7_draw", s_draw, 1);
`ifdef VGA_TIMING_BORDER_EN
    chk("s7_border", s_border, 1);
`endif
    step(1); chk("s8_draw", s_draw, 0);
`ifdef VGA_TIMING_BORDER_EN
    chk("s8_border", s_border, 0);
`endif
    step(2); chk("s10_hs", s_hs, 1);
    step(1); chk("s11_hs", s_hs, 1);
    step(1); chk("s12_hs", s_hs, 0);
    step(2); chk("s14_h", s_h, 0); chk("s14_v", s_v, 1); chk("s14_ls", s_ls, 1); chk("s14_fs", s_fs, 0);
    step(3); chk("s17_draw", s_draw, 1);
`ifdef VGA_TIMING_BORDER_EN
    chk("s17_border", s_border, 0);
    step(4); chk("s21_border", s_border, 1);
    step(35);
`else
    step(39);
`endif
    chk("s56_v", s_v, 4); chk("s56_draw", s_draw, 0);
    step(13); chk("s69_vs", s_vs, 1);
    step(1);  chk("s70_v", s_v, 5); chk("s70_vs", s_vs, 0);
    step(13); chk("s83_vs", s_vs, 0);
    step(1);  chk("s84_vs", s_vs, 1);
    step(14); chk("s98_h", s_h, 0); chk("s98_v", s_v, 0); chk("s98_fs", s_fs, 1);
    n_fs = 0;
    repeat (98) begin
      @(negedge clk);
      if (s_fs) n_fs++;
    end
    chk("frame_fs_cnt", n_fs, 1);
    n_fs = 0; n_ls = 0;
    for (int k = 0; k < 392; k++) begin
      en_s = (k % 4 == 3);
      @(negedge clk);
      if (s_fs) n_fs++;
      if (s_ls) n_ls++;
    end
    chk("duty_fs_cnt", n_fs, 1); chk("duty_ls_cnt", n_ls, 7);
    chk("duty_h", s_h, 0); chk("duty_v", s_v, 0); chk("duty_fs_last", s_fs, 1);
    en_s = 1'b0;
    step(1);
    chk("duty_hold_h", s_h, 0); chk("duty_hold_fs", s_fs, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
